pc_redirect_unit: RTL and testbench
===================================

// Module: pc_redirect_unit
// PURPOSE
//  Fetch-stage next-PC generator: owns the PC register, arbitrates N prioritised redirect sources
//  (exception, jr, jump/jal, branch, ...) against sequential PC+4, and tolerates fetch stalls.
//  A redirect raised while fetch cannot advance is buffered, so it is never lost.
//  Sits between the M-stage control outputs and the instruction-memory request logic.
// PARAMETERS
//  N_SRC     4             number of redirect sources; index 0 = highest priority (exception)
//  RESET_PC  32'hBFC0_0000 PC value loaded by reset
// PORTS
//  clk            in   1         single clock, rising edge
//  rst            in   1         synchronous, active-high reset
//  redir_valid    in   N_SRC     per-source redirect request, level, sampled each cycle
//  redir_pc       in   32*N_SRC  target for source i in bits [32*i+31:32*i]
//  fe_ready       in   1         fetch accepts the current PC this cycle (not stalled, addr accepted)
//  pcF            out  32        current fetch PC (registered)
//  pc_validF      out  1         pcF is a real fetch address
//  pc_plus4F      out  32        pcF + 4, combinational
//  redir_taken    out  1         1-cycle pulse: PC was loaded from a redirect at this clock edge
//  redir_src      out  clog2(N)  source index of the redirect applied, valid with redir_taken
//  redir_pending  out  1         a buffered redirect is waiting for fe_ready
//  pc_adelF       out  1         pcF[1:0] != 0 (address-error exception for fetch), combinational
// BEHAVIOUR
//  Reset (rst=1 at edge): pcF=RESET_PC, pc_validF=0, redir_taken=0, redir_src=0,
//   redir_pending=0, state=BOOT. All registered outputs are driven by reset values in the same cycle.
//  States: BOOT -> RUN unconditionally after 1 cycle (pc_validF becomes 1, pcF stays RESET_PC).
//   RUN -> PEND when a redirect arrives and fe_ready=0. PEND -> RUN when the buffered redirect is applied.
//  Arbitration: sel = lowest index i with redir_valid[i]=1; target = redir_pc[sel]. Pure combinational.
//  RUN, fe_ready=1: any redirect valid -> pcF<=target, redir_taken=1, redir_src=sel;
//   otherwise pcF<=pcF+4 (32-bit wrap, no carry out).
//  RUN, fe_ready=0: pcF holds. Any redirect valid -> buffer {sel, target}, go to PEND.
//  PEND, fe_ready=0: pcF holds. A new redirect with index <= buffered index overwrites the buffer
//   (fresh request wins a tie); a lower-priority one (higher index) is dropped.
//  PEND, fe_ready=1: the winner of {buffer, fresh redirect this cycle} by the same rule is loaded.
//   Result: redir_taken=1, redir_src=winner, go to RUN, redir_pending=0 next cycle.
//  redir_pending = (state==PEND). Latency: redirect accepted with fe_ready=1 -> pcF updated next edge.
//  BOOT ignores redir_valid and fe_ready. A redirect in BOOT is not buffered.
//  Reset during PEND discards the buffer. No exception to reset priority.
//  No alignment masking: misaligned targets load as-is and raise pc_adelF while they are in pcF.
// STRUCTURE
//  Shared header cpu_defs.vh: RESET_PC value, redirect source index constants
//   (SRC_EXC=0, SRC_JR=1, SRC_JUMP=2, SRC_BRANCH=3), and state encodings (BOOT/RUN/PEND).
//  Sub-module redir_prio_sel (N_SRC-wide fixed-priority select -> {any, idx, target}).
//   Instantiated once for the live inputs. Buffer-vs-fresh compare is inline.
// TESTING
//  1 Reset: assert rst 2 cycles, release -> pcF=BFC00000, pc_validF=0 for 1 cycle, then 1;
//    with fe_ready=1 the sequence is BFC00004, BFC00008.
//  2 Priority: redir_valid=4'b1010, pc1=80000100, pc3=80000200, fe_ready=1
//    -> next pcF=80000100, redir_src=1, redir_taken for 1 cycle.
//  3 Stall buffering: fe_ready=0, branch (src3) to 80001000 for 1 cycle, then 3 idle stalled cycles
//    -> redir_pending=1, pcF holds; fe_ready=1 -> pcF=80001000, redir_src=3, pending clears.
//  4 Override in PEND: buffered src3 pending, exception src0 to BFC00380 while fe_ready=0
//    -> buffer src0; on fe_ready=1 pcF=BFC00380. A later src3 while src0 is pending is dropped.
//  5 Wrap/alignment: pcF=FFFFFFFC, fe_ready=1 -> pcF=00000000. Redirect to 80000002 -> pc_adelF=1.
//  6 Reset mid-PEND: rst while redir_pending=1 -> pending=0, pcF=BFC00000, no redir_taken afterwards.

Source files
------------

// File: rtl/pc_redirect_unit_pkg.sv
// Shared constants for the fetch-stage next-PC logic: reset vector, redirect source indices
// and FSM state encoding.
package pc_redirect_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

    localparam int unsigned SRC_EXC    = 0;
    localparam int unsigned SRC_JR     = 1;
    localparam int unsigned SRC_JUMP   = 2;
    localparam int unsigned SRC_BRANCH = 3;

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StPend = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_redirect_unit_prio_sel.sv
// Fixed-priority redirect select: the lowest-indexed valid source wins and supplies the target.
module pc_redirect_unit_prio_sel #(
    parameter int unsigned NSrc = 4,
    parameter int unsigned IdxW = (NSrc > 1) ? $clog2(NSrc) : 1
) (
    input  logic [NSrc-1:0]    valid,
    input  logic [32*NSrc-1:0] pc_in,
    output logic               any,
    output logic [IdxW-1:0]    idx,
    output logic [31:0]        target
);

    always_comb begin
        any    = 1'b0;
        idx    = '0;
        target = '0;
        // Walk from lowest to highest priority so the last hit (lowest index) sticks.
        for (int i = int'(NSrc) - 1; i >= 0; i--) begin
            if (valid[i]) begin
                any    = 1'b1;
                idx    = IdxW'(i);
                target = pc_in[32*i +: 32];
            end
        end
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch-stage PC register with prioritised redirects; a redirect seen while fetch is stalled
// is held in a one-entry buffer until fetch can take it.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter int unsigned   N_SRC    = 4,
    parameter logic [31:0]   RESET_PC = RESET_PC_DEF,
    localparam int unsigned  SRC_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     redir_valid,
    input  logic [32*N_SRC-1:0]  redir_pc,
    input  logic                 fe_ready,
    output logic [31:0]          pcF,
    output logic                 pc_validF,
    output logic [31:0]          pc_plus4F,
    output logic                 redir_taken,
    output logic [SRC_W-1:0]     redir_src,
    output logic                 redir_pending,
    output logic                 pc_adelF
);

    pc_state_e        state_q;
    logic [SRC_W-1:0] buf_idx_q;
    logic [31:0]      buf_pc_q;

    logic             sel_any;
    logic [SRC_W-1:0] sel_idx;
    logic [31:0]      sel_target;
    logic             fresh_wins;

    pc_redirect_unit_prio_sel #(
        .NSrc (N_SRC),
        .IdxW (SRC_W)
    ) u_prio_sel (
        .valid  (redir_valid),
        .pc_in  (redir_pc),
        .any    (sel_any),
        .idx    (sel_idx),
        .target (sel_target)
    );

    // Fresh request beats the buffer on equal priority so the newest target of a source is kept.
    assign fresh_wins = sel_any && (sel_idx <= buf_idx_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StBoot;
            pcF         <= RESET_PC;
            pc_validF   <= 1'b0;
            redir_taken <= 1'b0;
            redir_src   <= '0;
            buf_idx_q   <= '0;
            buf_pc_q    <= '0;
        end else begin
            redir_taken <= 1'b0;
            unique case (state_q)
                StBoot: begin
                    pc_validF <= 1'b1;
                    state_q   <= StRun;
                end
                StRun: begin
                    if (fe_ready) begin
                        if (sel_any) begin
                            pcF         <= sel_target;
                            redir_taken <= 1'b1;
                            redir_src   <= sel_idx;
                        end else begin
                            pcF <= pcF + 32'd4;
                        end
                    end else if (sel_any) begin
                        buf_idx_q <= sel_idx;
                        buf_pc_q  <= sel_target;
                        state_q   <= StPend;
                    end
                end
                StPend: begin
                    if (fe_ready) begin
                        pcF         <= fresh_wins ? sel_target : buf_pc_q;
                        redir_src   <= fresh_wins ? sel_idx : buf_idx_q;
                        redir_taken <= 1'b1;
                        state_q     <= StRun;
                    end else if (fresh_wins) begin
                        buf_idx_q <= sel_idx;
                        buf_pc_q  <= sel_target;
                    end
                end
                default: state_q <= StBoot;
            endcase
        end
    end

    assign redir_pending = (state_q == StPend);
    assign pc_plus4F     = pcF + 32'd4;
    assign pc_adelF      = |pcF[1:0];

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: reset, priority, stall buffering, PEND override,
// wrap/alignment and reset during a pending redirect.
module tb_pc_redirect_unit;

    localparam int unsigned N_SRC = 4;

    logic                clk;
    logic                rst;
    logic [N_SRC-1:0]    redir_valid;
    logic [32*N_SRC-1:0] redir_pc;
    logic                fe_ready;
    logic [31:0]         pcF;
    logic                pc_validF;
    logic [31:0]         pc_plus4F;
    logic                redir_taken;
    logic [1:0]          redir_src;
    logic                redir_pending;
    logic                pc_adelF;

    int checks = 0;
    int errors = 0;

    pc_redirect_unit #(
        .N_SRC    (N_SRC),
        .RESET_PC (32'hBFC0_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redir_valid   (redir_valid),
        .redir_pc      (redir_pc),
        .fe_ready      (fe_ready),
        .pcF           (pcF),
        .pc_validF     (pc_validF),
        .pc_plus4F     (pc_plus4F),
        .redir_taken   (redir_taken),
        .redir_src     (redir_src),
        .redir_pending (redir_pending),
        .pc_adelF      (pc_adelF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_pc(input int idx, input logic [31:0] val);
        redir_pc[32*idx +: 32] = val;
    endtask

    initial begin
        rst         = 1'b1;
        redir_valid = '0;
        redir_pc    = '0;
        fe_ready    = 1'b0;

        // 1: reset and boot
        tick();
        tick();
        chk("rst_pc", pcF, 32'hBFC0_0000);
        chk("rst_valid", {31'd0, pc_validF}, 32'd0);
        chk("rst_pending", {31'd0, redir_pending}, 32'd0);
        chk("rst_taken", {31'd0, redir_taken}, 32'd0);
        rst      = 1'b0;
        fe_ready = 1'b1;
        chk("boot_valid0", {31'd0, pc_validF}, 32'd0);
        tick();
        chk("boot_valid1", {31'd0, pc_validF}, 32'd1);
        chk("boot_pc", pcF, 32'hBFC0_0000);
        tick();
        chk("seq_pc4", pcF, 32'hBFC0_0004);
        tick();
        chk("seq_pc8", pcF, 32'hBFC0_0008);
        chk("seq_plus4", pc_plus4F, 32'hBFC0_000C);

        // 2: priority src1 over src3
        redir_valid = 4'b1010;
        set_pc(1, 32'h8000_0100);
        set_pc(3, 32'h8000_0200);
        tick();
        chk("prio_pc", pcF, 32'h8000_0100);
        chk("prio_src", {30'd0, redir_src}, 32'd1);
        chk("prio_taken", {31'd0, redir_taken}, 32'd1);
        redir_valid = '0;
        tick();
        chk("prio_taken_clr", {31'd0, redir_taken}, 32'd0);
        chk("prio_seq", pcF, 32'h8000_0104);

        // 3: branch during stall is buffered
        fe_ready    = 1'b0;
        redir_valid = 4'b1000;
        set_pc(3, 32'h8000_1000);
        tick();
        redir_valid = '0;
        chk("stall_pend", {31'd0, redir_pending}, 32'd1);
        chk("stall_hold", pcF, 32'h8000_0104);
        chk("stall_taken", {31'd0, redir_taken}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pend_k", {31'd0, redir_pending}, 32'd1);
            chk("stall_hold_k", pcF, 32'h8000_0104);
        end
        fe_ready = 1'b1;
        tick();
        chk("unstall_pc", pcF, 32'h8000_1000);
        chk("unstall_src", {30'd0, redir_src}, 32'd3);
        chk("unstall_taken", {31'd0, redir_taken}, 32'd1);
        chk("unstall_pend", {31'd0, redir_pending}, 32'd0);
        tick();
        chk("unstall_seq", pcF, 32'h8000_1004);
        chk("unstall_taken_clr", {31'd0, redir_taken}, 32'd0);

        // 4: exception overrides buffered branch, later branch dropped
        fe_ready    = 1'b0;
        redir_valid = 4'b1000;
        set_pc(3, 32'h8000_2000);
        tick();
        redir_valid = 4'b0001;
        set_pc(0, 32'hBFC0_0380);
        tick();
        redir_valid = 4'b1000;
        set_pc(3, 32'h8000_3000);
        tick();
        chk("ovr_pend", {31'd0, redir_pending}, 32'd1);
        redir_valid = '0;
        fe_ready    = 1'b1;
        tick();
        chk("ovr_pc", pcF, 32'hBFC0_0380);
        chk("ovr_src", {30'd0, redir_src}, 32'd0);
        chk("ovr_pend_clr", {31'd0, redir_pending}, 32'd0);

        // 4b: fresh higher-priority request on the release cycle wins over the buffer
        fe_ready    = 1'b0;
        redir_valid = 4'b1000;
        set_pc(3, 32'h8000_5000);
        tick();
        fe_ready    = 1'b1;
        redir_valid = 4'b0100;
        set_pc(2, 32'h8000_4000);
        tick();
        redir_valid = '0;
        chk("fresh_pc", pcF, 32'h8000_4000);
        chk("fresh_src", {30'd0, redir_src}, 32'd2);

        // 5: wrap and misalignment
        redir_valid = 4'b0100;
        set_pc(2, 32'hFFFF_FFFC);
        tick();
        redir_valid = '0;
        chk("wrap_pre", pcF, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4F, 32'h0000_0000);
        tick();
        chk("wrap_pc", pcF, 32'h0000_0000);
        chk("wrap_adel", {31'd0, pc_adelF}, 32'd0);
        redir_valid = 4'b0001;
        set_pc(0, 32'h8000_0002);
        tick();
        redir_valid = '0;
        chk("mis_pc", pcF, 32'h8000_0002);
        chk("mis_adel", {31'd0, pc_adelF}, 32'd1);
        tick();
        chk("mis_seq", pcF, 32'h8000_0006);

        // 6: reset while pending; redirect in BOOT is ignored
        fe_ready    = 1'b0;
        redir_valid = 4'b1000;
        set_pc(3, 32'h8000_5000);
        tick();
        chk("rp_pend", {31'd0, redir_pending}, 32'd1);
        redir_valid = '0;
        rst         = 1'b1;
        tick();
        chk("rp_pend_clr", {31'd0, redir_pending}, 32'd0);
        chk("rp_pc", pcF, 32'hBFC0_0000);
        chk("rp_valid", {31'd0, pc_validF}, 32'd0);
        rst         = 1'b0;
        fe_ready    = 1'b1;
        redir_valid = 4'b0001;
        set_pc(0, 32'h8000_6000);
        tick();
        redir_valid = '0;
        chk("rp_boot_pc", pcF, 32'hBFC0_0000);
        chk("rp_boot_taken", {31'd0, redir_taken}, 32'd0);
        chk("rp_boot_pend", {31'd0, redir_pending}, 32'd0);
        tick();
        chk("rp_seq", pcF, 32'hBFC0_0004);
        chk("rp_taken", {31'd0, redir_taken}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
